// File: rtl/instr_arbiter.sv
// instr_arbiter: round-robin arbiter handing one processor to four command requesters
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req[3:0]                   per-requester request, held until ack
//   instr_in, reg{1,2,3}_in,   packed per-requester command fields (requester i in slice i)
//   const_in
//   grant[3:0], ack[3:0]       one-hot owner, one-cycle completion pulse
//   busy                       command loaded or running
//   p_instr..p_const, p_done   command bus to the processor and its done flag
//   timeout_err                sticky watchdog error
module instr_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [11:0] instr_in,
    input  logic [19:0] reg1_in,
    input  logic [19:0] reg2_in,
    input  logic [19:0] reg3_in,
    input  logic [63:0] const_in,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic        busy,
    output logic [2:0]  p_instr,
    output logic [4:0]  p_reg1,
    output logic [4:0]  p_reg2,
    output logic [4:0]  p_reg3,
    output logic [15:0] p_const,
    input  logic        p_done,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, ACK} state_t;
    localparam logic [2:0] NOP = 3'b001;

    state_t      r_state, w_next;
    logic [1:0]  r_ptr, r_owner, w_win;
    logic [4:0]  r_wd;
    logic [2:0]  r_instr;
    logic [4:0]  r_reg1, r_reg2, r_reg3;
    logic [15:0] r_const;
    logic        r_timeout;
    logic        w_to, w_drive, w_done;

    // Descending scan so the requester closest above ptr wins.
    always_comb begin
        w_win = r_ptr;
        for (int k = 3; k >= 0; k--)
            if (req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
    end

    assign w_to = (r_state == LOAD || r_state == RUN) && r_wd == 5'd31;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = |req ? LOAD : IDLE;
            LOAD:    w_next = w_to ? IDLE : p_done ? RUN : LOAD;
            RUN:     w_next = w_to ? IDLE : p_done ? ACK : RUN;
            default: w_next = IDLE;
        endcase
    end

    // Done in RUN means the command finished; show NOP so it is not relaunched.
    assign w_drive     = r_state == LOAD || (r_state == RUN && !p_done);
    assign w_done      = r_state == ACK || w_to;
    assign grant       = r_state != IDLE ? 4'b0001 << r_owner : 4'b0000;
    assign ack         = w_done ? grant : 4'b0000;
    assign busy        = r_state == LOAD || r_state == RUN;
    assign timeout_err = r_timeout;
    assign p_instr     = w_drive ? r_instr : NOP;
    assign p_reg1      = w_drive ? r_reg1 : 5'd0;
    assign p_reg2      = w_drive ? r_reg2 : 5'd0;
    assign p_reg3      = w_drive ? r_reg3 : 5'd0;
    assign p_const     = w_drive ? r_const : 16'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= 2'd0;
            r_owner   <= 2'd0;
            r_wd      <= 5'd0;
            r_timeout <= 1'b0;
            r_instr   <= NOP;
            r_reg1    <= 5'd0;
            r_reg2    <= 5'd0;
            r_reg3    <= 5'd0;
            r_const   <= 16'd0;
        end else begin
            if (r_state == IDLE && |req) begin
                r_owner <= w_win;
                r_instr <= instr_in[3*w_win +: 3];
                r_reg1  <= reg1_in[5*w_win +: 5];
                r_reg2  <= reg2_in[5*w_win +: 5];
                r_reg3  <= reg3_in[5*w_win +: 5];
                r_const <= const_in[16*w_win +: 16];
                r_wd    <= 5'd0;
            end
            if (busy) r_wd <= r_wd + 5'd1;
            if (w_done) begin
                r_ptr   <= r_owner + 2'd1;
                r_instr <= NOP;
                r_reg1  <= 5'd0;
                r_reg2  <= 5'd0;
                r_reg3  <= 5'd0;
                r_const <= 16'd0;
            end
            if (w_to) r_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_arbiter.sv
// tb_instr_arbiter: directed bench for instr_arbiter with a small processor model
module tb_instr_arbiter;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [3:0]  req = 0;
    logic [11:0] instr_in = 0;
    logic [19:0] reg1_in = 0, reg2_in = 0, reg3_in = 0;
    logic [63:0] const_in = 0;
    logic [3:0]  grant, ack;
    logic        busy, timeout_err;
    logic [2:0]  p_instr;
    logic [4:0]  p_reg1, p_reg2, p_reg3;
    logic [15:0] p_const;
    logic        p_done = 1;

    int checks = 0, errors = 0;
    int lat, e0, ack3_cnt = 0, a3;
    bit stuck = 0;

    // Processor: launches a non-NOP command while done, body takes two cycles.
    logic [15:0] rf [32] = '{1: 16'd3, 2: 16'd4, default: 16'd0};
    int          execs = 0, p_cnt = 0;
    logic [2:0]  q_instr;
    logic [4:0]  q_r1, q_r2, q_r3;
    logic [15:0] q_c;

    instr_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .instr_in(instr_in),
        .reg1_in(reg1_in), .reg2_in(reg2_in), .reg3_in(reg3_in), .const_in(const_in),
        .grant(grant), .ack(ack), .busy(busy),
        .p_instr(p_instr), .p_reg1(p_reg1), .p_reg2(p_reg2), .p_reg3(p_reg3),
        .p_const(p_const), .p_done(p_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (p_cnt != 0) begin
            if (!stuck) begin
                p_cnt <= p_cnt - 1;
                if (p_cnt == 1) begin
                    p_done <= 1;
                    execs  <= execs + 1;
                    if (q_instr == 3'b000) rf[q_r3] <= q_c;
                    else if (q_instr == 3'b101) rf[q_r3] <= rf[q_r1] + rf[q_r2];
                end
            end
        end else if (p_done && p_instr != 3'b001) begin
            q_instr <= p_instr;
            q_r1    <= p_reg1;
            q_r2    <= p_reg2;
            q_r3    <= p_reg3;
            q_c     <= p_const;
            p_done  <= 0;
            p_cnt   <= 2;
        end
    end

    always @(negedge clk) if (ack[3]) ack3_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic [2:0] op, input logic [4:0] r1, r2, r3,
                           input logic [15:0] c);
        instr_in[3*i +: 3]  = op;
        reg1_in[5*i +: 5]   = r1;
        reg2_in[5*i +: 5]   = r2;
        reg3_in[5*i +: 5]   = r3;
        const_in[16*i +: 16] = c;
    endtask

    task automatic wait_done(input string tag, input logic v);
        for (int n = 0; n < 100 && p_done !== v; n++) @(negedge clk);
        chk(tag, p_done, v);
    endtask

    // Waits for the grant to exp, then its ack; lat counts cycles from grant to ack.
    task automatic serve(input string tag, input int exp, input logic [3:0] dropm, output int l);
        for (int n = 0; n < 100 && grant == 0; n++) @(negedge clk);
        chk({tag, "_grant"}, grant, 32'(1) << exp);
        l = 0;
        while (ack == 0 && l < 100) begin
            @(negedge clk);
            l++;
        end
        chk({tag, "_ack"}, ack, 32'(1) << exp);
        req &= ~dropm;
        @(negedge clk);
        chk({tag, "_ack_pulse"}, ack, 0);
        chk({tag, "_grant_clr"}, grant, 0);
    endtask

    initial begin
        #12;
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_instr", p_instr, 3'b001);
        chk("rst_const", p_const, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 4; i++) set_cmd(i, 3'b000, 0, 0, 5'(10 + i), 16'(16'hA0 + i));
        req = 4'hF;
        for (int i = 0; i < 4; i++) serve("all4", i, 4'(1 << i), lat);
        chk("all4_rf10", rf[10], 16'hA0);
        chk("all4_rf13", rf[13], 16'hA3);

        set_cmd(0, 3'b000, 0, 0, 5, 16'h1234);
        req = 4'b0001;
        serve("single", 0, 4'b0001, lat);
        chk("single_lat", lat, 4);
        chk("single_rf5", rf[5], 16'h1234);
        chk("single_idle_instr", p_instr, 3'b001);

        set_cmd(1, 3'b101, 1, 2, 7, 0);
        req = 4'b0010;
        e0 = execs;
        for (int n = 0; n < 100 && grant == 0; n++) @(negedge clk);
        chk("add_load_instr", p_instr, 3'b101);
        chk("add_load_reg3", p_reg3, 7);
        wait_done("add_launch", 0);
        wait_done("add_done", 1);
        chk("add_nop_instr", p_instr, 3'b001);
        chk("add_nop_reg1", p_reg1, 0);
        chk("add_busy", busy, 1);
        serve("add", 1, 4'b0010, lat);
        repeat (3) @(negedge clk);
        chk("add_rf7", rf[7], 7);
        chk("add_once", execs, e0 + 1);

        set_cmd(1, 3'b000, 0, 0, 8, 16'd11);
        set_cmd(2, 3'b000, 0, 0, 9, 16'd22);
        req = 4'b0110;
        serve("alt1", 2, 4'b0000, lat);
        serve("alt2", 1, 4'b0000, lat);
        serve("alt3", 2, 4'b0000, lat);
        serve("alt4", 1, 4'b0110, lat);

        set_cmd(3, 3'b000, 0, 0, 12, 16'd77);
        stuck = 1;
        req = 4'b1000;
        serve("wdog", 3, 4'b1000, lat);
        chk("wdog_lat", lat, 31);
        chk("wdog_terr", timeout_err, 1);
        chk("wdog_busy", busy, 0);
        chk("wdog_nop", p_instr, 3'b001);
        stuck = 0;
        wait_done("wdog_recover", 1);
        set_cmd(0, 3'b000, 0, 0, 14, 16'd55);
        req = 4'b0001;
        serve("after_wdog", 0, 4'b0001, lat);
        chk("after_wdog_terr", timeout_err, 1);
        chk("after_wdog_rf14", rf[14], 16'd55);

        set_cmd(3, 3'b101, 1, 2, 15, 0);
        req = 4'b1000;
        for (int n = 0; n < 100 && grant == 0; n++) @(negedge clk);
        chk("abort_grant", grant, 4'b1000);
        wait_done("abort_run", 0);
        a3 = ack3_cnt;
        #2 rst_n = 0;
        #1;
        chk("abort_grant_clr", grant, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack", ack, 0);
        chk("abort_nop", p_instr, 3'b001);
        chk("abort_terr", timeout_err, 0);
        req = 0;
        repeat (5) @(negedge clk);
        chk("abort_no_ack3", ack3_cnt, a3);
        rst_n = 1;
        set_cmd(1, 3'b000, 0, 0, 16, 16'd99);
        req = 4'b1010;
        serve("post_rst", 1, 4'b0010, lat);
        chk("post_rst_rf16", rf[16], 16'd99);
        serve("post_rst3", 3, 4'b1000, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
